// File: rtl/button_if.sv
// Button bundle between the pad side (master) and the conditioner (slave).
// Every vector carries one bit per channel.
interface button_if #(
    parameter int N_CH = 5
);
    logic [N_CH-1:0] noisy_in;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] repeat_pulse;

    modport master (
        output noisy_in,
        input  level,
        input  press_pulse,
        input  release_pulse,
        input  repeat_pulse
    );

    modport slave (
        input  noisy_in,
        output level,
        output press_pulse,
        output release_pulse,
        output repeat_pulse
    );
endinterface

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: synchroniser, stability filter, and
// registered press / release / auto-repeat pulses per independent channel.
module button_conditioner #(
    parameter int N_CH          = 5,
    parameter int STABLE_CYCLES = 16,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 16
) (
    input  logic    clk,
    input  logic    rst_n,
    button_if.slave bus
);
    localparam int CW   = $clog2(STABLE_CYCLES + 1);
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);
    localparam bit            REP_ON   = (REPEAT_EN != 32'sd0);

    logic [N_CH-1:0] level_v_s;
    logic [N_CH-1:0] press_v_s;
    logic [N_CH-1:0] release_v_s;
    logic [N_CH-1:0] repeat_v_s;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic          s1_r;
        logic          s2_r;
        logic          level_r;
        logic          press_r;
        logic          release_r;
        logic          repeat_r;
        logic          ph_r;
        logic [CW-1:0] cnt_r;
        logic [HW-1:0] hcnt_r;
        logic          flip_s;
        logic          hold_last_s;

        // Terminal-count decode for the stability filter and the hold timer.
        always_comb begin
            flip_s      = 1'b0;
            hold_last_s = 1'b0;
            if ((s2_r != level_r) && (cnt_r == CNT_LAST)) begin
                flip_s = 1'b1;
            end else begin
                flip_s = 1'b0;
            end
            if (ph_r) begin
                hold_last_s = (hcnt_r == PER_LAST);
            end else begin
                hold_last_s = (hcnt_r == DLY_LAST);
            end
        end

        // Synchroniser, debounce filter, level/pulse registers and repeat timer.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_r      <= 1'b0;
                s2_r      <= 1'b0;
                level_r   <= 1'b0;
                cnt_r     <= '0;
                hcnt_r    <= '0;
                ph_r      <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                repeat_r  <= 1'b0;
            end else begin
                s1_r      <= bus.noisy_in[g];
                s2_r      <= s1_r;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                repeat_r  <= 1'b0;

                if (s2_r == level_r) begin
                    cnt_r <= '0;
                end else if (flip_s) begin
                    level_r   <= s2_r;
                    cnt_r     <= '0;
                    press_r   <= s2_r;
                    release_r <= ~s2_r;
                end else begin
                    cnt_r <= cnt_r + 1'b1;
                end

                // A press edge lands here too (level_r still 0), which restarts the delay phase.
                if (!REP_ON || !level_r || flip_s) begin
                    hcnt_r <= '0;
                    ph_r   <= 1'b0;
                end else if (hold_last_s) begin
                    repeat_r <= 1'b1;
                    hcnt_r   <= '0;
                    ph_r     <= 1'b1;
                end else begin
                    hcnt_r <= hcnt_r + 1'b1;
                end
            end
        end

        assign level_v_s[g]   = level_r;
        assign press_v_s[g]   = press_r;
        assign release_v_s[g] = release_r;
        assign repeat_v_s[g]  = repeat_r;
    end

    assign bus.level         = level_v_s;
    assign bus.press_pulse   = press_v_s;
    assign bus.release_pulse = release_v_s;
    assign bus.repeat_pulse  = repeat_v_s;
endmodule
